// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load write-backs into the single register-file write port through an in-order FIFO.
// Latency: an entry accepted at edge N is at the head in the next cycle and is written at edge N+1 when idle.
// Backpressure: AluReady/MemReady drop when the registered Count leaves too few free slots (Rd==0 is always ready).
// Optional bypass lookup of queued entries: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     AluValid,
    input  logic [4:0]               AluRd,
    input  logic [31:0]              AluData,
    output logic                     AluReady,
    input  logic                     MemValid,
    input  logic [4:0]               MemRd,
    input  logic [31:0]              MemData,
    output logic                     MemReady,
    input  logic                     Hold,
    output logic                     RuWr,
    output logic [4:0]               Rd,
    output logic [31:0]              RuDataWr,
    input  logic [4:0]               Rs1,
    input  logic [4:0]               Rs2,
    output logic                     Byp1Hit,
    output logic                     Byp2Hit,
    output logic [31:0]              Byp1Data,
    output logic [31:0]              Byp2Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          prio;

    logic [AW:0]   free;
    logic          alu_nz;
    logic          mem_nz;
    logic          prio_tgl;
    logic          alu_push;
    logic          mem_push;
    logic          first_push;
    logic          second_push;
    entry_t        first_ent;
    entry_t        second_ent;
    logic [1:0]    n_push;
    logic          pop;

    // Free slots come from the registered Count only; a same-cycle pop is not credited.
    assign free   = (AW+1)'(DEPTH) - Count;
    assign alu_nz = AluValid && (AluRd != 5'd0);
    assign mem_nz = MemValid && (MemRd != 5'd0);

    // Ready arbitration: Rd==0 always ready, contention resolved by the round-robin pointer.
    always_comb begin
        AluReady = 1'b1;
        MemReady = 1'b1;
        prio_tgl = 1'b0;
        if (alu_nz && mem_nz) begin
            if (free >= (AW+1)'(2)) begin
                prio_tgl = 1'b1;
            end else if (free == (AW+1)'(1)) begin
                AluReady = !prio;
                MemReady = prio;
                prio_tgl = 1'b1;
            end else begin
                AluReady = 1'b0;
                MemReady = 1'b0;
            end
        end else begin
            if (AluRd != 5'd0) AluReady = (free != '0);
            if (MemRd != 5'd0) MemReady = (free != '0);
        end
    end

    assign alu_push = alu_nz && AluReady;
    assign mem_push = mem_nz && MemReady;
    assign n_push   = {1'b0, alu_push} + {1'b0, mem_push};

    // Order the two pushes so the priority source lands in the older slot.
    always_comb begin
        if (!prio) begin
            first_push  = alu_push;
            first_ent   = '{rd: AluRd, dat: AluData};
            second_push = mem_push;
            second_ent  = '{rd: MemRd, dat: MemData};
        end else begin
            first_push  = mem_push;
            first_ent   = '{rd: MemRd, dat: MemData};
            second_push = alu_push;
            second_ent  = '{rd: AluRd, dat: AluData};
        end
    end

    assign Empty    = (Count == '0);
    assign RuWr     = !Empty && !Hold;
    assign pop      = RuWr;
    assign Rd       = Empty ? 5'd0  : fifo_q[rd_ptr].rd;
    assign RuDataWr = Empty ? 32'd0 : fifo_q[rd_ptr].dat;

    // Pointer, occupancy and round-robin state; reset discards everything queued.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            Count  <= '0;
            prio   <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            wr_ptr <= wr_ptr + AW'(n_push);
            Count  <= Count + (AW+1)'(n_push) - (AW+1)'(pop);
            if (prio_tgl) prio <= !prio;
        end
    end

    // Entry storage; unoccupied slots are never observed so no reset is needed.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (first_push) fifo_q[wr_ptr] <= first_ent;
            if (second_push) fifo_q[first_push ? wr_ptr + AW'(1) : wr_ptr] <= second_ent;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Scan occupied entries oldest to youngest so the youngest match wins.
    always_comb begin
        Byp1Hit  = 1'b0;
        Byp1Data = 32'd0;
        Byp2Hit  = 1'b0;
        Byp2Data = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < Count) begin
                if (Rs1 != 5'd0 && fifo_q[rd_ptr + AW'(k)].rd == Rs1) begin
                    Byp1Hit  = 1'b1;
                    Byp1Data = fifo_q[rd_ptr + AW'(k)].dat;
                end
                if (Rs2 != 5'd0 && fifo_q[rd_ptr + AW'(k)].rd == Rs2) begin
                    Byp2Hit  = 1'b1;
                    Byp2Data = fifo_q[rd_ptr + AW'(k)].dat;
                end
            end
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{Rs1, Rs2};
    assign Byp1Hit   = 1'b0;
    assign Byp2Hit   = 1'b0;
    assign Byp1Data  = 32'd0;
    assign Byp2Data  = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin order,
// Hold backpressure, Rd==0 requests, bypass lookup and reset mid-operation.
// Register-file writes are recorded at negedge and compared against hand-computed order.
module tb_regfile_wb_arbiter;
    logic        Clk;
    logic        Rst;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemRd;
    logic [31:0] MemData;
    logic        MemReady;
    logic        Hold;
    logic        RuWr;
    logic [4:0]  Rd;
    logic [31:0] RuDataWr;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        Byp1Hit;
    logic        Byp2Hit;
    logic [31:0] Byp1Data;
    logic [31:0] Byp2Data;
    logic [2:0]  Count;
    logic        Empty;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
        .Hold(Hold), .RuWr(RuWr), .Rd(Rd), .RuDataWr(RuDataWr),
        .Rs1(Rs1), .Rs2(Rs2),
        .Byp1Hit(Byp1Hit), .Byp2Hit(Byp2Hit), .Byp1Data(Byp1Data), .Byp2Data(Byp2Data),
        .Count(Count), .Empty(Empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every register-file write mid-cycle, away from the edge.
    always @(negedge Clk) begin
        if (RuWr === 1'b1) wq.push_back('{Rd, RuDataWr});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] wq_at(input int i);
        if (i < wq.size()) return {27'd0, wq[i].rd, wq[i].d};
        return {64{1'bx}};
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (Empty !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, Empty, 1);
    endtask

    initial begin
        Rst = 1'b1; Hold = 1'b0;
        AluValid = 1'b0; AluRd = 5'd0; AluData = 32'd0;
        MemValid = 1'b0; MemRd = 5'd0; MemData = 32'd0;
        Rs1 = 5'd0; Rs2 = 5'd0;
        cyc();
        cyc();

        // Reset state
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_ruwr", RuWr, 0);
        chk("rst_rd", Rd, 0);
        chk("rst_data", RuDataWr, 0);
        chk("rst_byp", {Byp1Hit, Byp2Hit, Byp1Data, Byp2Data}, 0);

        // A request accepted while Rst is high is dropped
        AluValid = 1'b1; AluRd = 5'd3; AluData = 32'h99;
        #1;
        chk("rst_aluready", AluReady, 1);
        cyc();
        Rst = 1'b0; AluValid = 1'b0;
        #1;
        chk("rst_drop_count", Count, 0);

        // Single write
        wq.delete();
        AluValid = 1'b1; AluRd = 5'd5; AluData = 32'hDEADBEEF;
        #1;
        chk("single_ready", AluReady, 1);
        cyc();
        AluValid = 1'b0;
        #1;
        chk("single_ruwr", RuWr, 1);
        chk("single_rd", Rd, 5);
        chk("single_data", RuDataWr, 32'hDEADBEEF);
        chk("single_count", Count, 1);
        cyc();
        chk("single_empty", Empty, 1);
        chk("single_nwr", wq.size(), 1);
        chk("single_wr0", wq_at(0), {27'd0, 5'd5, 32'hDEADBEEF});

        // Round-robin ordering
        wq.delete();
        AluValid = 1'b1; AluRd = 5'd1; AluData = 32'h11;
        MemValid = 1'b1; MemRd = 5'd3; MemData = 32'h33;
        #1;
        chk("rr_ready_a", {AluReady, MemReady}, 2'b11);
        cyc();
        AluRd = 5'd2; AluData = 32'h22;
        MemRd = 5'd4; MemData = 32'h44;
        #1;
        chk("rr_count", Count, 2);
        chk("rr_ready_b", {AluReady, MemReady}, 2'b11);
        cyc();
        AluValid = 1'b0; MemValid = 1'b0;
        #1;
        chk("rr_count3", Count, 3);
        drain("rr_drain");
        chk("rr_nwr", wq.size(), 4);
        chk("rr_wr0", wq_at(0), {27'd0, 5'd1, 32'h11});
        chk("rr_wr1", wq_at(1), {27'd0, 5'd3, 32'h33});
        chk("rr_wr2", wq_at(2), {27'd0, 5'd4, 32'h44});
        chk("rr_wr3", wq_at(3), {27'd0, 5'd2, 32'h22});

        // Hold fills the FIFO; Prio is back to 0 so ALU goes first
        wq.delete();
        Hold = 1'b1;
        AluValid = 1'b1; AluRd = 5'd5; AluData = 32'h55;
        MemValid = 1'b1; MemRd = 5'd6; MemData = 32'h66;
        cyc();
        AluRd = 5'd8; AluData = 32'h88;
        MemRd = 5'd9; MemData = 32'h99;
        #1;
        chk("hold_ready2", {AluReady, MemReady}, 2'b11);
        cyc();
        AluRd = 5'd10; AluData = 32'hAA;
        MemRd = 5'd11; MemData = 32'hBB;
        #1;
        chk("hold_count4", Count, 4);
        chk("hold_ready0", {AluReady, MemReady}, 2'b00);
        chk("hold_ruwr", RuWr, 0);

        // Rd==0 request while full
        AluRd = 5'd0; AluData = 32'hBAD;
        #1;
        chk("rd0_ready", {AluReady, MemReady}, 2'b10);
        cyc();
        chk("rd0_count", Count, 4);

        // Release Hold; acceptance resumes one cycle after the first pop
        AluRd = 5'd10; AluData = 32'hAA; Hold = 1'b0;
        #1;
        chk("rel_ready0", {AluReady, MemReady}, 2'b00);
        chk("rel_head", {RuWr, Rd}, {1'b1, 5'd5});
        cyc();
        chk("rel_ready_prio", {AluReady, MemReady}, 2'b10);
        chk("rel_count3", Count, 3);
        cyc();
        AluValid = 1'b0;
        #1;
        chk("rel_mem_ready", MemReady, 1);
        cyc();
        MemValid = 1'b0;
        drain("hold_drain");
        chk("hold_nwr", wq.size(), 6);
        chk("hold_wr0", wq_at(0), {27'd0, 5'd5, 32'h55});
        chk("hold_wr1", wq_at(1), {27'd0, 5'd6, 32'h66});
        chk("hold_wr2", wq_at(2), {27'd0, 5'd9, 32'h99});
        chk("hold_wr3", wq_at(3), {27'd0, 5'd8, 32'h88});
        chk("hold_wr4", wq_at(4), {27'd0, 5'd10, 32'hAA});
        chk("hold_wr5", wq_at(5), {27'd0, 5'd11, 32'hBB});

        // Bypass lookup
        wq.delete();
        Hold = 1'b1;
        AluValid = 1'b1; AluRd = 5'd7; AluData = 32'h1;
        cyc();
        AluData = 32'h2;
        cyc();
        AluValid = 1'b0;
        Rs1 = 5'd7; Rs2 = 5'd0;
        #1;
        chk("byp_count", Count, 2);
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp1", {Byp1Hit, Byp1Data}, {1'b1, 32'h2});
`else
        chk("byp1", {Byp1Hit, Byp1Data}, {1'b0, 32'h0});
`endif
        chk("byp2_rs0", {Byp2Hit, Byp2Data}, {1'b0, 32'h0});
        Rs2 = 5'd5;
        AluValid = 1'b1; AluRd = 5'd9; AluData = 32'h3; Rs1 = 5'd9;
        #1;
        chk("byp_inflight", {Byp1Hit, Byp1Data}, {1'b0, 32'h0});
        chk("byp2_miss", {Byp2Hit, Byp2Data}, {1'b0, 32'h0});
        cyc();
        AluValid = 1'b0;
        #1;
        chk("byp_count3", Count, 3);
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp1_new", {Byp1Hit, Byp1Data}, {1'b1, 32'h3});
`else
        chk("byp1_new", {Byp1Hit, Byp1Data}, {1'b0, 32'h0});
`endif

        // Reset mid-operation
        Rst = 1'b1;
        cyc();
        Rst = 1'b0; Hold = 1'b0;
        #1;
        chk("mrst_count", Count, 0);
        chk("mrst_ruwr", RuWr, 0);
        chk("mrst_empty", Empty, 1);
        cyc();
        cyc();
        cyc();
        chk("mrst_nwr", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
